// File: rtl/result_accum_pkg.sv
// Shared definitions for the result accumulation bank: default widths,
// FSM state encoding and a small state-decode helper.
package result_accum_pkg;

  localparam int DEF_ADDR_WIDTH   = 7;
  localparam int DEF_RESULT_WIDTH = 24;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } accum_state_e;

  // True in the two resting states where commands and readback are honoured.
  function automatic logic is_quiet(input accum_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/result_dp_ram.sv
// True dual-port RAM, 1-cycle registered read on both ports.
// When both ports write the same address in one cycle, port B's data is kept.
module result_dp_ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q_a_r;
  logic [DATA_WIDTH-1:0] q_b_r;

  // Both ports share one process so the port B write is applied last and wins.
  always_ff @(posedge clock) begin
    if (we_a) begin
      mem_r[addr_a] <= din_a;
    end
    if (we_b) begin
      mem_r[addr_b] <= din_b;
    end
    q_a_r <= mem_r[addr_a];
    q_b_r <= mem_r[addr_b];
  end

  assign q_a = q_a_r;
  assign q_b = q_b_r;

endmodule

// File: rtl/result_accum_bank.sv
// Result accumulation bank: two write lanes store results into a dual-port
// RAM while summing them; the RAM is zeroed two words per cycle on reset or
// on request, and can be read back while the bank is idle.
// Optional feature: define RESULT_ACCUM_SAT_EN to saturate the accumulator
// instead of letting it wrap (sum_overflow is set either way).
module result_accum_bank
  import result_accum_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH        = 2**ADDR_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int SUM_WIDTH    = RESULT_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clear_req,
  input  logic                    wr_valid_a,
  input  logic                    wr_valid_b,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_a,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_b,
  input  logic [RESULT_WIDTH-1:0] wr_data_a,
  input  logic [RESULT_WIDTH-1:0] wr_data_b,
  input  logic                    wr_last,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_en,
  output logic [RESULT_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic [SUM_WIDTH-1:0]    matrix_sum,
  output logic                    sum_overflow,
  output logic                    addr_err,
  output logic                    collision
);

  // Wide enough to hold accumulator + two lane values without losing the carry.
  localparam int EXT_W = ((SUM_WIDTH > RESULT_WIDTH) ? SUM_WIDTH : RESULT_WIDTH) + 2;
  localparam logic [EXT_W-1:0]      SUM_MAX_EXT = EXT_W'({SUM_WIDTH{1'b1}});
  localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST    = ADDR_WIDTH'((DEPTH + 1) / 2 - 1);

  accum_state_e state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [ADDR_WIDTH:0]   clr_odd_s;

  logic                    acc_a_s, acc_b_s, in_range_a_s, in_range_b_s, last_s, start_go_s;
  logic                    pend_va_r, pend_vb_r;
  logic [ADDR_WIDTH-1:0]   pend_addr_a_r, pend_addr_b_r;
  logic [RESULT_WIDTH-1:0] pend_data_a_r, pend_data_b_r;
  logic                    collision_r;

  logic [EXT_W-1:0]     add_a_s, add_b_s, sum_ext_s;
  logic                 carry_s;
  logic [SUM_WIDTH-1:0] acc_next_s;
  logic [SUM_WIDTH-1:0] acc_r;
  logic                 sum_overflow_r, addr_err_r;
  logic                 busy_r, done_r, wr_ready_r, rd_valid_r;

  logic                    ram_we_a_s, ram_we_b_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_a_s, ram_addr_b_s;
  logic [RESULT_WIDTH-1:0] ram_din_a_s, ram_din_b_s;
  logic [RESULT_WIDTH-1:0] ram_q_a_s;
  logic [RESULT_WIDTH-1:0] unused_q_b_s;

  assign acc_a_s      = wr_valid_a & wr_ready_r;
  assign acc_b_s      = wr_valid_b & wr_ready_r;
  assign in_range_a_s = ({1'b0, wr_addr_a} < DEPTH_W);
  assign in_range_b_s = ({1'b0, wr_addr_b} < DEPTH_W);
  assign last_s       = wr_last & wr_ready_r & (wr_valid_a | wr_valid_b);
  assign start_go_s   = start & is_quiet(state_r);
  assign clr_odd_s    = {clr_cnt_r, 1'b1};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start outranks clear_req and both only act when quiet.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == CLR_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next_s = ST_ACCUM;
        end else if (clear_req) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_ACCUM: begin
        if (last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_DRAIN: state_next_s = ST_DONE;
      default:  state_next_s = ST_CLEAR;
    endcase
  end

  // Clear sweep counter: one even/odd word pair per cycle, parked at 0 otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if ((state_r == ST_CLEAR) && (clr_cnt_r != CLR_LAST)) begin
      clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
    end else begin
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end
  end

  // Capture accepted in-range beats for the write cycle; flag same-address pairs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_va_r     <= 1'b0;
      pend_vb_r     <= 1'b0;
      pend_addr_a_r <= {ADDR_WIDTH{1'b0}};
      pend_addr_b_r <= {ADDR_WIDTH{1'b0}};
      pend_data_a_r <= {RESULT_WIDTH{1'b0}};
      pend_data_b_r <= {RESULT_WIDTH{1'b0}};
      collision_r   <= 1'b0;
    end else begin
      pend_va_r     <= acc_a_s & in_range_a_s;
      pend_vb_r     <= acc_b_s & in_range_b_s;
      pend_addr_a_r <= wr_addr_a;
      pend_addr_b_r <= wr_addr_b;
      pend_data_a_r <= wr_data_a;
      pend_data_b_r <= wr_data_b;
      collision_r   <= acc_a_s & in_range_a_s & acc_b_s & in_range_b_s &
                       (wr_addr_a == wr_addr_b);
    end
  end

  // Next accumulator value: wrap or clamp on carry-out.
  always_comb begin
    add_a_s    = {EXT_W{1'b0}};
    add_b_s    = {EXT_W{1'b0}};
    if (pend_va_r) begin
      add_a_s = EXT_W'(pend_data_a_r);
    end else begin
      add_a_s = {EXT_W{1'b0}};
    end
    if (pend_vb_r) begin
      add_b_s = EXT_W'(pend_data_b_r);
    end else begin
      add_b_s = {EXT_W{1'b0}};
    end
    sum_ext_s = EXT_W'(acc_r) + add_a_s + add_b_s;
    carry_s   = (sum_ext_s > SUM_MAX_EXT);
`ifdef RESULT_ACCUM_SAT_EN
    if (carry_s) begin
      acc_next_s = {SUM_WIDTH{1'b1}};
    end else begin
      acc_next_s = sum_ext_s[SUM_WIDTH-1:0];
    end
`else
    acc_next_s = sum_ext_s[SUM_WIDTH-1:0];
`endif
  end

  // Accumulator and sticky flags, zeroed when an operation starts.
  always_ff @(posedge clock) begin
    if (reset || start_go_s) begin
      acc_r          <= {SUM_WIDTH{1'b0}};
      sum_overflow_r <= 1'b0;
      addr_err_r     <= 1'b0;
    end else begin
      acc_r          <= acc_next_s;
      sum_overflow_r <= sum_overflow_r | carry_s;
      addr_err_r     <= addr_err_r | (acc_a_s & ~in_range_a_s) | (acc_b_s & ~in_range_b_s);
    end
  end

  // Status outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      wr_ready_r <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      busy_r     <= ~is_quiet(state_next_s);
      done_r     <= (state_next_s == ST_DONE);
      wr_ready_r <= (state_next_s == ST_ACCUM);
      rd_valid_r <= rd_en & is_quiet(state_r);
    end
  end

  // RAM port steering: clear sweep, pending lane writes, or readback on port A.
  always_comb begin
    ram_we_a_s   = 1'b0;
    ram_we_b_s   = 1'b0;
    ram_addr_a_s = rd_addr;
    ram_addr_b_s = pend_addr_b_r;
    ram_din_a_s  = pend_data_a_r;
    ram_din_b_s  = pend_data_b_r;
    if (reset) begin
      ram_we_a_s = 1'b0;
      ram_we_b_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      ram_we_a_s   = 1'b1;
      ram_addr_a_s = ADDR_WIDTH'({clr_cnt_r, 1'b0});
      ram_din_a_s  = {RESULT_WIDTH{1'b0}};
      ram_we_b_s   = (clr_odd_s < DEPTH_W);
      ram_addr_b_s = ADDR_WIDTH'(clr_odd_s);
      ram_din_b_s  = {RESULT_WIDTH{1'b0}};
    end else begin
      ram_we_a_s = pend_va_r;
      ram_we_b_s = pend_vb_r;
      if (pend_va_r) begin
        ram_addr_a_s = pend_addr_a_r;
      end else begin
        ram_addr_a_s = rd_addr;
      end
    end
  end

  result_dp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (RESULT_WIDTH)
  ) u_ram (
    .clock  (clock),
    .we_a   (ram_we_a_s),
    .addr_a (ram_addr_a_s),
    .din_a  (ram_din_a_s),
    .q_a    (ram_q_a_s),
    .we_b   (ram_we_b_s),
    .addr_b (ram_addr_b_s),
    .din_b  (ram_din_b_s),
    .q_b    (unused_q_b_s)
  );

  assign wr_ready     = wr_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign rd_valid     = rd_valid_r;
  assign rd_data      = rd_valid_r ? ram_q_a_s : {RESULT_WIDTH{1'b0}};
  assign matrix_sum   = done_r ? acc_r : {SUM_WIDTH{1'b0}};
  assign sum_overflow = sum_overflow_r;
  assign addr_err     = addr_err_r;
  assign collision    = collision_r;

endmodule

// File: tb/tb_result_accum_bank.sv
// Self-checking bench: two bank instances (full depth / wide sum, and
// DEPTH=100 / SUM_WIDTH=8) share one stimulus stream and are compared with
// an array-based reference model of the storage and the running sum.
module tb_result_accum_bank;

  localparam int AW  = 7;
  localparam int RW  = 24;
  localparam int D0  = 128;
  localparam int SW0 = RW + AW + 1;
  localparam int D1  = 100;
  localparam int SW1 = 8;

  typedef struct {
    bit              va;
    int              aa;
    longint unsigned da;
    bit              vb;
    int              ab;
    longint unsigned db;
  } beat_t;

  logic clock = 1'b0;
  logic reset, start, clear_req, wr_valid_a, wr_valid_b, wr_last, rd_en;
  logic [AW-1:0] wr_addr_a, wr_addr_b, rd_addr;
  logic [RW-1:0] wr_data_a, wr_data_b;

  logic wr_ready_0, rd_valid_0, busy_0, done_0, sum_overflow_0, addr_err_0, collision_0;
  logic wr_ready_1, rd_valid_1, busy_1, done_1, sum_overflow_1, addr_err_1, collision_1;
  logic [RW-1:0]  rd_data_0, rd_data_1;
  logic [SW0-1:0] matrix_sum_0;
  logic [SW1-1:0] matrix_sum_1;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned mem [2][128];
  longint unsigned acc [2];
  bit              ovf [2];
  bit              aerr [2];
  int              depth [2] = '{D0, D1};
  int              sw [2]    = '{SW0, SW1};
  beat_t           beats [$];

  always #5 clock = ~clock;

  result_accum_bank #(.ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .clear_req(clear_req),
    .wr_valid_a(wr_valid_a), .wr_valid_b(wr_valid_b), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .wr_last(wr_last), .wr_ready(wr_ready_0), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data_0), .rd_valid(rd_valid_0), .busy(busy_0), .done(done_0),
    .matrix_sum(matrix_sum_0), .sum_overflow(sum_overflow_0),
    .addr_err(addr_err_0), .collision(collision_0));

  result_accum_bank #(.ADDR_WIDTH(AW), .DEPTH(D1), .RESULT_WIDTH(RW), .SUM_WIDTH(SW1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .clear_req(clear_req),
    .wr_valid_a(wr_valid_a), .wr_valid_b(wr_valid_b), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .wr_last(wr_last), .wr_ready(wr_ready_1), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data_1), .rd_valid(rd_valid_1), .busy(busy_1), .done(done_1),
    .matrix_sum(matrix_sum_1), .sum_overflow(sum_overflow_1),
    .addr_err(addr_err_1), .collision(collision_1));

  task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: apply one beat to instance d using the storage/sum rules.
  task automatic model_beat(input int d, input beat_t b, output bit coll);
    longint unsigned mx = (64'd1 << sw[d]) - 64'd1;
    longint unsigned t  = acc[d];
    bit ina = b.va && (b.aa < depth[d]);
    bit inb = b.vb && (b.ab < depth[d]);
    if (ina) begin t += b.da; mem[d][b.aa] = b.da; end
    if (inb) begin t += b.db; mem[d][b.ab] = b.db; end
    if ((b.va && !ina) || (b.vb && !inb)) aerr[d] = 1'b1;
    coll = ina && inb && (b.aa == b.ab);
    if (t > mx) begin
      ovf[d] = 1'b1;
`ifdef RESULT_ACCUM_SAT_EN
      t = mx;
`else
      t = t % (mx + 64'd1);
`endif
    end
    acc[d] = t;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < depth[d]; a++) mem[d][a] = 64'd0;
  endtask

  task automatic drive_idle();
    start = 1'b0; clear_req = 1'b0; wr_valid_a = 1'b0; wr_valid_b = 1'b0;
    wr_last = 1'b0; rd_en = 1'b0;
  endtask

  task automatic drive_beat(input beat_t b, input bit last);
    wr_valid_a = b.va; wr_addr_a = AW'(b.aa); wr_data_a = RW'(b.da);
    wr_valid_b = b.vb; wr_addr_b = AW'(b.ab); wr_data_b = RW'(b.db);
    wr_last = last;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready0"}, wr_ready_0, 0);   check_val({tag, "_ready1"}, wr_ready_1, 0);
    check_val({tag, "_done0"}, done_0, 0);        check_val({tag, "_done1"}, done_1, 0);
    check_val({tag, "_busy0"}, busy_0, 1);        check_val({tag, "_busy1"}, busy_1, 1);
    check_val({tag, "_rdv0"}, rd_valid_0, 0);     check_val({tag, "_rdd0"}, rd_data_0, 0);
    check_val({tag, "_sum0"}, matrix_sum_0, 0);   check_val({tag, "_sum1"}, matrix_sum_1, 0);
    check_val({tag, "_ovf0"}, sum_overflow_0, 0); check_val({tag, "_aerr1"}, addr_err_1, 0);
    check_val({tag, "_coll0"}, collision_0, 0);   check_val({tag, "_coll1"}, collision_1, 0);
  endtask

  // Starts on the negedge where both instances have just entered the clear sweep.
  task automatic wait_clear(input string tag);
    int n, n0, n1;
    n = 0; n0 = -1; n1 = -1;
    while (n < 300 && (busy_0 || busy_1)) begin
      @(negedge clock);
      n++;
      if (!busy_0 && n0 < 0) n0 = n;
      if (!busy_1 && n1 < 0) n1 = n;
    end
    check_val({tag, "_len0"}, longint'(n0), (D0 + 1) / 2);
    check_val({tag, "_len1"}, longint'(n1), (D1 + 1) / 2);
    model_clear();
  endtask

  task automatic read_chk(input int addr);
    rd_en = 1'b1; rd_addr = AW'(addr);
    @(negedge clock);
    rd_en = 1'b0;
    check_val("rd_valid0", rd_valid_0, 1);
    check_val("rd_valid1", rd_valid_1, 1);
    check_val($sformatf("rd0[%0d]", addr), rd_data_0, mem[0][addr]);
    check_val($sformatf("rd1[%0d]", addr), rd_data_1, mem[1][addr]);
  endtask

  // Runs one operation over the queued beats; entered and left on a negedge.
  task automatic run_op(input bit also_clear);
    bit c0, c1;
    start = 1'b1; clear_req = also_clear;
    @(negedge clock);
    check_val("op_ready0", wr_ready_0, 1); check_val("op_ready1", wr_ready_1, 1);
    check_val("op_busy0", busy_0, 1);      check_val("op_done0", done_0, 0);
    for (int d = 0; d < 2; d++) begin acc[d] = 0; ovf[d] = 0; aerr[d] = 0; end
    for (int i = 0; i < beats.size(); i++) begin
      drive_beat(beats[i], i == beats.size() - 1);
      start     = ($urandom_range(0, 3) == 0);
      clear_req = ($urandom_range(0, 3) == 0);
      model_beat(0, beats[i], c0);
      model_beat(1, beats[i], c1);
      @(negedge clock);
      check_val($sformatf("coll0_b%0d", i), collision_0, c0);
      check_val($sformatf("coll1_b%0d", i), collision_1, c1);
    end
    drive_idle();
    check_val("drain_done0", done_0, 0);     check_val("drain_ready0", wr_ready_0, 0);
    check_val("drain_sum0", matrix_sum_0, 0);
    @(negedge clock);
    check_val("done0", done_0, 1);            check_val("done1", done_1, 1);
    check_val("busy0", busy_0, 0);            check_val("busy1", busy_1, 0);
    check_val("sum0", matrix_sum_0, acc[0]);  check_val("sum1", matrix_sum_1, acc[1]);
    check_val("ovf0", sum_overflow_0, ovf[0]); check_val("ovf1", sum_overflow_1, ovf[1]);
    check_val("aerr0", addr_err_0, aerr[0]);  check_val("aerr1", addr_err_1, aerr[1]);
  endtask

  function automatic beat_t mk(input bit va, input int aa, input longint unsigned da,
                               input bit vb, input int ab, input longint unsigned db);
    beat_t b;
    b.va = va; b.aa = aa; b.da = da; b.vb = vb; b.ab = ab; b.db = db;
    return b;
  endfunction

  initial begin
    int nb;
    beat_t b;
    reset = 1'b1; rd_addr = '0; wr_addr_a = '0; wr_addr_b = '0;
    wr_data_a = '0; wr_data_b = '0;
    drive_idle();
    for (int d = 0; d < 2; d++) for (int a = 0; a < 128; a++) mem[d][a] = 64'd0;
    @(negedge clock); @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;
    wait_clear("clr_rst");
    read_chk(5);
    @(negedge clock);
    check_val("rd_idle_v0", rd_valid_0, 0); check_val("rd_idle_d0", rd_data_0, 0);

    // Basic two-beat-plus-last operation.
    beats.delete();
    beats.push_back(mk(1, 0, 10, 1, 1, 20));
    beats.push_back(mk(1, 2, 30, 0, 0, 0));
    run_op(1'b0);
    check_val("basic_sum60", matrix_sum_0, 60);
    read_chk(1);
    check_val("basic_rd20", rd_data_0, 20);

    // Same-address pair: lane B data kept, both values summed.
    beats.delete();
    beats.push_back(mk(1, 7, 5, 1, 7, 9));
    run_op(1'b0);
    check_val("coll_sum14", matrix_sum_0, 14);
    read_chk(7);
    check_val("coll_rd9", rd_data_0, 9);

    // Address 120 is out of range only for the DEPTH=100 instance.
    beats.delete();
    beats.push_back(mk(1, 120, 50, 0, 0, 0));
    run_op(1'b0);
    check_val("oor_aerr1", addr_err_1, 1);
    check_val("oor_sum1", matrix_sum_1, 0);

    // 200 + 100 through an 8-bit accumulator.
    beats.delete();
    beats.push_back(mk(1, 0, 200, 0, 0, 0));
    beats.push_back(mk(1, 1, 100, 0, 0, 0));
    run_op(1'b0);
`ifdef RESULT_ACCUM_SAT_EN
    check_val("sat_sum1", matrix_sum_1, 255);
`else
    check_val("wrap_sum1", matrix_sum_1, 44);
`endif
    check_val("ovf_flag1", sum_overflow_1, 1);
    check_val("nowrap_sum0", matrix_sum_0, 300);

    // Clear request from DONE.
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    check_val("clr_done0", done_0, 0); check_val("clr_busy0", busy_0, 1);
    wait_clear("clr_req");
    read_chk(0); read_chk(1);

    // Randomised operations; op 2 also raises clear_req alongside start.
    for (int op = 0; op < 6; op++) begin
      nb = $urandom_range(3, 10);
      beats.delete();
      for (int i = 0; i < nb; i++) begin
        b.va = ($urandom_range(0, 3) != 0) || (i == nb - 1);
        b.aa = $urandom_range(0, 127);
        b.da = $urandom_range(0, 24'hFFFFFF);
        b.vb = ($urandom_range(0, 3) != 0);
        b.ab = ($urandom_range(0, 3) == 0) ? b.aa : $urandom_range(0, 127);
        b.db = $urandom_range(0, 24'hFFFFFF);
        beats.push_back(b);
      end
      run_op(op == 2);
      for (int r = 0; r < 4; r++) read_chk($urandom_range(0, D1 - 1));
      if (beats[nb - 1].aa < D1) read_chk(beats[nb - 1].aa);
    end

    // Reset in the middle of an operation, with a collision write pending.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drive_beat(mk(1, 3, 77, 0, 0, 0), 1'b0);
    @(negedge clock);
    drive_beat(mk(1, 7, 5, 1, 7, 9), 1'b0);
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    wait_clear("clr_mid");
    read_chk(3); read_chk(7);
    beats.delete();
    beats.push_back(mk(1, 4, 11, 0, 0, 0));
    run_op(1'b0);
    check_val("after_rst_sum11", matrix_sum_0, 11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
